// File: rtl/mem_pkg.sv
// Shared definitions for the byte-addressable data memory: access size
// encodings, default decode base and the byte-enable helper.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_WORD    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } size_e;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0200_0000;

  // Lane mask for a store; misaligned halves are filtered out by the caller.
  function automatic logic [3:0] byte_enables(input size_e size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: byte_enables = 4'b0001 << lane;
      SZ_HALF: byte_enables = 4'b0011 << lane;
      SZ_WORD: byte_enables = 4'b1111;
      default: byte_enables = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load path: moves the addressed byte or half down to bit 0 and applies
// sign or zero extension.
module dmem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  size_e       size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    // NOTE: every output gets a default before the case so no latch can be inferred.
    data    = '0;
    shifted = word >> {lane, 3'b000};
    case (size)
      SZ_BYTE: data = is_unsigned ? {24'h0, shifted[7:0]}
                                  : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: data = is_unsigned ? {16'h0, shifted[15:0]}
                                  : {{16{shifted[15]}}, shifted[15:0]};
      SZ_WORD: data = shifted;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_bytes.sv
// Byte-addressable data RAM with byte/half/word loads and stores, a
// valid/ready request/response handshake and one-cycle registered responses.
module data_mem_bytes
  import mem_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = DEFAULT_BASE_ADDR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int                  IDX_W   = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] LO_ADDR = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] HI_ADDR = LO_ADDR + (ADDR_WIDTH+1)'(4 * DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  size_e                 size;
  logic [1:0]            lane;
  logic [IDX_W-1:0]      widx;
  logic [ADDR_WIDTH:0]   addr_ext;
  logic                  in_range;
  logic                  misaligned;
  logic                  req_err;
  logic                  accept;
  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] load_data;

  assign size     = size_e'(req_size);
  assign lane     = req_addr[1:0];
  assign addr_ext = {1'b0, req_addr};
  // BASE_ADDR is word aligned, so subtracting only the index bits needs no borrow.
  assign widx     = req_addr[IDX_W+1:2] - BASE_ADDR[IDX_W+1:2];

  assign in_range   = (addr_ext >= LO_ADDR) && (addr_ext <= HI_ADDR);
  assign misaligned = ((size == SZ_HALF) && lane[0]) ||
                      ((size == SZ_WORD) && (lane != 2'b00));
  assign req_err    = !in_range || (size == SZ_ILLEGAL) || misaligned;

  assign req_ready = !rsp_valid || rsp_ready;
  assign accept    = req_valid && req_ready;

  assign be = byte_enables(size, lane);

  always_comb begin
    wr_data = req_wdata;
    case (size)
      SZ_BYTE: wr_data = {4{req_wdata[7:0]}};
      SZ_HALF: wr_data = {2{req_wdata[15:0]}};
      default: wr_data = req_wdata;
    endcase
  end

  dmem_load_align u_align (
    .word        (mem[widx]),
    .lane        (lane),
    .size        (size),
    .is_unsigned (req_unsigned),
    .data        (load_data)
  );

  // NOTE: the RAM array is deliberately left out of reset; clearing it would
  // force flop-based storage and its contents must survive rst anyway.
  always_ff @(posedge clk) begin
    if (!rst && accept && req_we && !req_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_err   <= req_err;
      rsp_rdata <= (req_we || req_err) ? '0 : load_data;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_mem_bytes.sv
// Directed self-checking bench for data_mem_bytes with hand-computed
// expected values.
module tb_data_mem_bytes;
  import mem_pkg::*;

  localparam logic [31:0] BASE = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  data_mem_bytes dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  initial begin
    #200us;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Presents one request for exactly one edge; returns 1 time unit after it.
  task automatic apply(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata);
    req_we       = we;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wdata;
    req_valid    = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic expect_rsp(input string tag, input logic [31:0] rdata, input logic err);
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_rdata"}, rsp_rdata, rdata);
    check({tag, "_err"},   32'(rsp_err), 32'(err));
  endtask

  initial begin
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_addr     = '0;
    req_size     = '0;
    req_unsigned = 1'b0;
    req_wdata    = '0;
    rsp_ready    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 32'(rsp_valid), 32'd0);
    check("reset_rdata", rsp_rdata, 32'd0);
    check("reset_err",   32'(rsp_err), 32'd0);
    check("reset_ready", 32'(req_ready), 32'd1);
    rst = 1'b0;

    // Word store then load; response is present right after the accepting edge.
    apply(1'b1, BASE, SZ_WORD, 1'b0, 32'hDEAD_BEEF);
    expect_rsp("t1_sw", 32'h0, 1'b0);
    apply(1'b0, BASE, SZ_WORD, 1'b0, 32'h0);
    expect_rsp("t1_lw", 32'hDEAD_BEEF, 1'b0);

    // Byte store into lane 1 (upper wdata bits must be ignored).
    apply(1'b1, BASE + 32'd1, SZ_BYTE, 1'b0, 32'h1234_565A);
    expect_rsp("t2_sb", 32'h0, 1'b0);
    apply(1'b0, BASE + 32'd3, SZ_BYTE, 1'b0, 32'h0);
    expect_rsp("t2_lb", 32'hFFFF_FFDE, 1'b0);
    apply(1'b0, BASE + 32'd3, SZ_BYTE, 1'b1, 32'h0);
    expect_rsp("t2_lbu", 32'h0000_00DE, 1'b0);
    apply(1'b0, BASE + 32'd1, SZ_BYTE, 1'b1, 32'h0);
    expect_rsp("t2_lbu1", 32'h0000_005A, 1'b0);
    apply(1'b0, BASE, SZ_WORD, 1'b0, 32'h0);
    expect_rsp("t2_lw", 32'hDEAD_5AEF, 1'b0);

    // Half stores, extension and a misaligned half that must not write.
    apply(1'b1, BASE + 32'd4, SZ_WORD, 1'b0, 32'h1122_3344);
    expect_rsp("t3_sw", 32'h0, 1'b0);
    apply(1'b1, BASE + 32'd6, SZ_HALF, 1'b0, 32'hFFFF_8001);
    expect_rsp("t3_sh", 32'h0, 1'b0);
    apply(1'b0, BASE + 32'd6, SZ_HALF, 1'b0, 32'h0);
    expect_rsp("t3_lh", 32'hFFFF_8001, 1'b0);
    apply(1'b0, BASE + 32'd6, SZ_HALF, 1'b1, 32'h0);
    expect_rsp("t3_lhu", 32'h0000_8001, 1'b0);
    apply(1'b0, BASE + 32'd4, SZ_HALF, 1'b0, 32'h0);
    expect_rsp("t3_lh_lo", 32'h0000_3344, 1'b0);
    apply(1'b1, BASE + 32'd5, SZ_HALF, 1'b0, 32'h0000_ABCD);
    expect_rsp("t3_sh_mis", 32'h0, 1'b1);
    apply(1'b0, BASE + 32'd4, SZ_WORD, 1'b0, 32'h0);
    expect_rsp("t3_lw", 32'h8001_3344, 1'b0);

    // Range boundaries, illegal size and misaligned word.
    apply(1'b0, 32'h01FF_FFFC, SZ_WORD, 1'b0, 32'h0);
    expect_rsp("t4_below", 32'h0, 1'b1);
    apply(1'b0, 32'h0200_1000, SZ_WORD, 1'b0, 32'h0);
    expect_rsp("t4_above", 32'h0, 1'b1);
    apply(1'b1, 32'h0200_1000, SZ_WORD, 1'b0, 32'h0BAD_BAD0);
    expect_rsp("t4_sw_above", 32'h0, 1'b1);
    apply(1'b1, 32'h0200_0FFC, SZ_WORD, 1'b0, 32'hCAFE_F00D);
    expect_rsp("t4_sw_top", 32'h0, 1'b0);
    apply(1'b0, 32'h0200_0FFF, SZ_BYTE, 1'b0, 32'h0);
    expect_rsp("t4_lb_top", 32'hFFFF_FFCA, 1'b0);
    apply(1'b0, BASE, 2'b11, 1'b0, 32'h0);
    expect_rsp("t4_size11", 32'h0, 1'b1);
    apply(1'b0, BASE + 32'd2, SZ_WORD, 1'b0, 32'h0);
    expect_rsp("t4_lw_mis", 32'h0, 1'b1);
    apply(1'b0, BASE, SZ_WORD, 1'b0, 32'h0);
    expect_rsp("t4_no_alias", 32'hDEAD_5AEF, 1'b0);

    // Back-to-back loads, one response per cycle, in order.
    apply(1'b0, BASE, SZ_WORD, 1'b0, 32'h0);
    expect_rsp("t5_b0", 32'hDEAD_5AEF, 1'b0);
    check("t5_ready0", 32'(req_ready), 32'd1);
    apply(1'b0, BASE + 32'd3, SZ_BYTE, 1'b1, 32'h0);
    expect_rsp("t5_b1", 32'h0000_00DE, 1'b0);
    apply(1'b0, BASE + 32'd6, SZ_HALF, 1'b1, 32'h0);
    expect_rsp("t5_b2", 32'h0000_8001, 1'b0);

    // Stall: response held, request (a store) ignored.
    rsp_ready    = 1'b0;
    req_we       = 1'b1;
    req_addr     = BASE;
    req_size     = SZ_WORD;
    req_wdata    = 32'h5555_5555;
    req_valid    = 1'b1;
    #1;
    check("t5_stall_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      expect_rsp($sformatf("t5_hold%0d", i), 32'h0000_8001, 1'b0);
      check($sformatf("t5_hold%0d_ready", i), 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t5_drain_valid", 32'(rsp_valid), 32'd0);
    apply(1'b0, BASE, SZ_WORD, 1'b0, 32'h0);
    expect_rsp("t5_no_write", 32'hDEAD_5AEF, 1'b0);

    // Reset with a pending error response, then a store under reset.
    apply(1'b0, BASE, 2'b11, 1'b0, 32'h0);
    expect_rsp("t6_pre", 32'h0, 1'b1);
    rsp_ready = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    check("t6_rst_valid", 32'(rsp_valid), 32'd0);
    check("t6_rst_err",   32'(rsp_err), 32'd0);
    check("t6_rst_rdata", rsp_rdata, 32'd0);
    rsp_ready = 1'b1;
    apply(1'b1, BASE, SZ_WORD, 1'b0, 32'h7777_7777);
    check("t6_rst_store_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    apply(1'b0, BASE, SZ_WORD, 1'b0, 32'h0);
    expect_rsp("t6_keep0", 32'hDEAD_5AEF, 1'b0);
    apply(1'b0, BASE + 32'd4, SZ_WORD, 1'b0, 32'h0);
    expect_rsp("t6_keep1", 32'h8001_3344, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_mem_bytes.md
Name: data_mem_bytes

Overview:
Parametrised successor to the word-only data memory. Byte-addressable RAM supporting RISC-V byte, half and word loads and stores, with sign or zero extension on loads. Uses a valid/ready request and response handshake with registered (1-cycle) read data. Reports an error for misaligned accesses, out-of-range accesses and illegal sizes. Sits on the CPU load/store path, decoded at BASE_ADDR.

Parameters:
DATA_WIDTH, 32, data bus width; only 32 is supported (4 byte lanes).
ADDR_WIDTH, 32, request address width.
DEPTH, 1024, number of DATA_WIDTH words in the RAM; must be a power of two.
BASE_ADDR, 32'h02000000, byte address of word 0.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  block can accept a request this cycle.
req_we  input  1  1 = store, 0 = load.
req_addr  input  ADDR_WIDTH  byte address.
req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
req_wdata  input  DATA_WIDTH  store data, right-justified (byte in [7:0], half in [15:0]).
rsp_valid  output  1  response present.
rsp_ready  input  1  consumer accepts the response.
rsp_rdata  output  DATA_WIDTH  load data after extension; 0 for stores and errors.
rsp_err  output  1  access faulted; no memory state was changed.

Behaviour:
- Reset (rst=1 at the clock edge): rsp_valid=0, rsp_rdata=0, rsp_err=0. Any pending response is dropped. RAM contents are not cleared.
- req_ready = !rsp_valid || rsp_ready. This is combinational and allows one transaction per cycle at full throughput.
- Accept: a request is accepted on an edge where req_valid && req_ready.
- Response timing: the response appears on the edge that accepts the request (1-cycle latency).
- Response hold: rsp_valid, rsp_rdata and rsp_err stay stable until the edge where rsp_ready=1. On that edge, if no new request is accepted, rsp_valid is cleared to 0.
- Word index: widx = (req_addr - BASE_ADDR) >> 2, truncated to log2(DEPTH) bits. Lane = req_addr[1:0].
- In range means BASE_ADDR <= req_addr <= BASE_ADDR + 4*DEPTH - 1. Compare in ADDR_WIDTH+1 bits so there is no wrap-around.
- Error conditions (rsp_err=1, rsp_rdata=0, no write):
  - address out of range;
  - size=11;
  - half access with addr[0]=1;
  - word access with addr[1:0]!=0.
- Stores:
  - Byte enables are 0001 shifted by lane for a byte store, 0011 shifted by lane for a half store, and 1111 for a word store.
  - Write data is replicated across lanes: byte → {4{b}}, half → {2{h}}.
  - The write commits on the accepting edge.
  - The response is rsp_err=0, rsp_rdata=0.
- Loads:
  - The word is read at the accepting edge.
  - The selected byte or half is shifted to bit 0, then extended according to req_unsigned.
  - For word loads req_unsigned is ignored.
- Ordering: requests are handled strictly in order. A load accepted on the cycle after a store to the same bytes returns the stored data.
- While rsp_valid=1 and rsp_ready=0, the RAM is neither read nor written, and input requests are ignored.
- rst asserted in the same cycle as an accepted store: the write is suppressed (reset wins).

Decomposition:
- Package mem_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - the default BASE_ADDR constant;
  - a function computing byte enables from size and lane.
- Sub-module dmem_load_align: combinational lane select plus sign/zero extension (inputs: word, lane, size, unsigned).
- The top holds the RAM array, range/alignment checks and the response register.

Test Plan:
1. Store word 0xDEADBEEF at 0x02000000, then load word → rsp_rdata=0xDEADBEEF, rsp_err=0. Each response appears 1 cycle after acceptance.
2. After test 1, store byte 0x5A at 0x02000001, then:
   - load byte signed at 0x02000003 → 0xFFFFFFDE;
   - load byte unsigned at 0x02000003 → 0x000000DE;
   - load word at 0x02000000 → 0xDEAD5AEF.
3. Store half 0x8001 at 0x02000006, then:
   - load half signed → 0xFFFF8001;
   - load half unsigned → 0x00008001;
   - store half at 0x02000005 → rsp_err=1, and a subsequent word load of 0x02000004 is unchanged.
4. Load at 0x01FFFFFC and at BASE_ADDR + 4*DEPTH → rsp_err=1, rsp_rdata=0. Load with size=11 → rsp_err=1.
5. Back-to-back requests with rsp_ready=1 → one response per cycle, in order. Hold rsp_ready=0 for 3 cycles → req_ready=0 and the response is stable; a store presented during the stall does not write.
6. Assert rst while rsp_valid=1 → next cycle rsp_valid=0, rsp_err=0, rsp_rdata=0. Previously written RAM data remains readable after reset.
